// File: rtl/fmap_streamer.sv
// fmap_streamer: holds one LEN x LEN feature map in a register buffer and replays it
// row-major onto the pooling input, with GAP idle cycles between rows.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset (buffer contents are kept)
//   wr_en_i      buffer write strobe, honoured only while not busy
//   wr_addr_i    write address, row*LEN + col
//   wr_data_i    write data
//   start_i      single-cycle pulse that starts one frame
//   load_o       frame window to the pooling stage
//   conv_out_o   streamed element
//   valid_o      conv_out_o carries a new element this cycle
//   row_o/col_o  position of the current element
//   busy_o       frame in progress
//   done_o       one-cycle pulse after frame completion
module fmap_streamer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN   = 8,
    parameter int unsigned GAP   = 2,
    parameter int unsigned AW    = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   start_i,
    output logic                   load_o,
    output logic [WIDTH-1:0]       conv_out_o,
    output logic                   valid_o,
    output logic [$clog2(LEN)-1:0] row_o,
    output logic [$clog2(LEN)-1:0] col_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned RW    = $clog2(LEN);
    localparam int unsigned GW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned Depth = LEN * LEN;
    localparam logic [RW-1:0] LastIdx = RW'(LEN - 1);
    localparam logic [GW-1:0] GapLast = GW'((GAP > 0) ? GAP - 1 : 0);

    // state_q names the phase currently visible on the registered outputs
    typedef enum logic [2:0] {StIdle, StPre, StStream, StGap, StTail} state_e;

    state_e           state_q, state_d;
    logic             start_q;
    logic [RW-1:0]    row_q, row_d;
    logic [RW-1:0]    col_q, col_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             emit;
    logic [AW-1:0]    rd_addr;

    logic [WIDTH-1:0] mem_q [Depth];

    // Buffer is deliberately not reset; writes are locked out for the whole frame.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !busy_q && (32'(wr_addr_i) < Depth)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        gap_d   = gap_q;
        data_d  = data_q;
        load_d  = 1'b1;
        valid_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        emit    = 1'b0;
        rd_addr = '0;

        unique case (state_q)
            StIdle: begin
                load_d = 1'b0;
                busy_d = 1'b0;
                // start is registered first: this gives the one-edge launch latency and
                // lets a start sampled on the done edge be taken up here
                if (start_q) begin
                    state_d = StPre;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StPre: begin
                state_d = StStream;
                row_d   = '0;
                col_d   = '0;
                emit    = 1'b1;
            end
            StStream: begin
                if (col_q != LastIdx) begin
                    col_d = col_q + RW'(1);
                    emit  = 1'b1;
                end else if (row_q != LastIdx) begin
                    if (GAP > 0) begin
                        state_d = StGap;
                        gap_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                        col_d = '0;
                        emit  = 1'b1;
                    end
                end else begin
                    state_d = StTail;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StStream;
                    row_d   = row_q + RW'(1);
                    col_d   = '0;
                    emit    = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            StTail: begin
                state_d = StIdle;
                load_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
                load_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (emit) begin
            rd_addr = AW'(32'(row_d) * LEN + 32'(col_d));
            data_d  = mem_q[rd_addr];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_i;
            row_q   <= row_d;
            col_q   <= col_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            load_q  <= load_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign load_o     = load_q;
    assign conv_out_o = data_q;
    assign valid_o    = valid_q;
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
